uart_line_buffer: RTL and testbench
===================================

Name: uart_line_buffer

Overview:
Line-assembly stage between the UART receiver's byte stream and the UART transmitter's byte handshake. It collects received bytes into a local buffer and applies simple line editing (backspace, LF discard). On CR it replays the whole line to the transmitter, followed by CR LF. This replaces raw per-byte echo with line-at-a-time echo in the board's serial console path.

Parameters:
- DEPTH, 32, maximum stored line length in bytes (>=2); terminator not stored.
- LEN_W, $clog2(DEPTH+1), width of the length counter and line_len.

Ports:
- clk  input  1  system clock (27 MHz on board)
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received byte from UART receiver
- rx_data_valid  input  1  rx_data valid; upstream holds byte until accepted
- rx_data_ready  output  1  block can accept a byte
- tx_data  output  8  byte to UART transmitter
- tx_data_valid  output  1  tx_data valid
- tx_data_ready  input  1  transmitter accepts tx_data this cycle
- line_len  output  LEN_W  bytes currently stored
- overflow  output  1  sticky: at least one byte dropped in current line
- busy  output  1  line replay in progress

Behaviour:
- Clock/reset: one clock, clk; reset asynchronous, active-low, rst_n.
- Reset values: state COLLECT, tx_data=0x00, tx_data_valid=0, line_len=0, overflow=0, busy=0, rx_data_ready=1. Buffer contents are not reset.
- States: COLLECT, EMIT, EMIT_CR, EMIT_LF.
- rx_data_ready = (state==COLLECT), combinational. busy = (state!=COLLECT).
- Accept = rx_data_valid && rx_data_ready. In COLLECT, per accepted byte:
  - 0x0D: cnt>0 -> EMIT, rd_idx=0; cnt==0 -> EMIT_CR.
  - 0x0A: dropped, no state change.
  - 0x08 or 0x7F: cnt>0 -> cnt-1; cnt==0 -> ignored.
  - Other byte, cnt<DEPTH: buf[cnt]=byte, cnt+1.
  - Other byte, cnt==DEPTH: dropped, overflow<=1.
- tx_data and tx_data_valid are registered.
  - tx_data_valid rises the cycle after the state-entry edge, so the first tx byte is valid 1 cycle after CR is accepted.
  - Once tx_data_valid=1, tx_data is stable until a cycle with tx_data_ready=1.
  - Back-to-back transfers are allowed: the next byte is loaded on the handshake edge and valid stays high.
- EMIT: present buf[rd_idx]. On handshake:
  - rd_idx<cnt-1 -> rd_idx+1.
  - rd_idx==cnt-1 -> EMIT_CR.
- EMIT_CR: present 0x0D; on handshake -> EMIT_LF.
- EMIT_LF: present 0x0A; on handshake -> COLLECT with tx_data_valid=0, cnt=0, overflow=0.
- line_len = cnt. It is not cleared until EMIT_LF completes.
- Exactly cnt+2 tx transfers per line; no duplication or skip under any tx_data_ready pattern.
- Reset mid-operation (any state): outputs return to reset values immediately (asynchronous). The partial line is discarded.

Optional Feature:
- Macro: UART_LINE_UPPER_EN.
- Defined: bytes 0x61..0x7A are emitted minus 0x20 (uppercase) during EMIT. The buffer stores raw bytes; CR/LF are unaffected.
- Undefined: bytes are emitted exactly as stored.

Test Plan:
1. Reset, rx "abc",0x0D, tx_data_ready=1 -> line_len 3 before CR; tx sequence 61 62 63 0D 0A; rx_data_ready=0 and busy=1 from the CR-accept edge until the LF handshake; then back in COLLECT with line_len=0.
2. Empty line, rx 0x0D -> tx 0D 0A only. Then rx 0x0A -> no tx activity, line_len stays 0.
3. Editing, rx 0x7F (cnt 0), "ab",0x08,"c",0x0D -> tx 61 63 0D 0A. With UART_LINE_UPPER_EN defined -> 41 43 0D 0A.
4. Overflow, DEPTH=4, rx "ABCDEF",0x0D -> overflow=1 from the cycle after 'E' is accepted, line_len=4; tx 41 42 43 44 0D 0A; overflow=0 after the LF handshake.
5. Backpressure, rx "xyz",0x0D, tx_data_ready low 5 cycles while 'y' is presented, then random 50% -> tx_data held at 0x79 throughout the stall; total transfers 78 79 7A 0D 0A, none lost or repeated.
6. Reset mid-replay, rst_n low during EMIT of byte 2 -> tx_data_valid=0, line_len=0, busy=0, rx_data_ready=1 without a clock edge. A following "q",0x0D -> tx 71 0D 0A.

Source files
------------

// File: rtl/uart_line_buffer.sv
// rtl/uart_line_buffer.sv - line-assembly stage between UART receiver and transmitter
//
// Collects received bytes into a line buffer with simple editing:
// backspace/DEL remove the last byte and LF is dropped. On CR the stored
// line is replayed to the transmitter, followed by CR LF.
//
// Optional feature macro: UART_LINE_UPPER_EN. When defined, lowercase
// letters are emitted as uppercase during replay. The buffer always holds
// the raw bytes, and CR/LF are never altered.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rx_data        received byte from the UART receiver
//   rx_data_valid  rx_data valid; held by upstream until accepted
//   rx_data_ready  high while collecting (byte can be accepted)
//   tx_data        byte to the UART transmitter (registered)
//   tx_data_valid  tx_data valid (registered)
//   tx_data_ready  transmitter accepts tx_data this cycle
//   line_len       number of bytes currently stored
//   overflow       sticky: a byte was dropped in the current line
//   busy           line replay in progress

module uart_line_buffer #(
   parameter int DEPTH = 32,
   parameter int LEN_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_data_valid,
   output logic             rx_data_ready,
   output logic [7:0]       tx_data,
   output logic             tx_data_valid,
   input  logic             tx_data_ready,
   output logic [LEN_W-1:0] line_len,
   output logic             overflow,
   output logic             busy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      EMIT    = 2'd1,
      EMIT_CR = 2'd2,
      EMIT_LF = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [LEN_W-1:0] cnt_q;
   logic [LEN_W-1:0] rd_q;
   logic [LEN_W-1:0] rd_d;
   logic             overflow_q;
   logic [7:0]       next_byte;
   logic [7:0]       line_buf [DEPTH];

   logic accept;
   logic tx_hs;
   logic is_cr;
   logic is_lf;
   logic is_bs;
   logic is_data;

   function automatic logic [7:0] emit_map(input logic [7:0] b);
`ifdef UART_LINE_UPPER_EN
      if (b >= 8'h61 && b <= 8'h7A) begin
         return b - 8'h20;
      end
      return b;
`else
      return b;
`endif
   endfunction

   assign accept  = rx_data_valid && rx_data_ready;
   assign tx_hs   = tx_data_valid && tx_data_ready;
   assign is_cr   = (rx_data == 8'h0D);
   assign is_lf   = (rx_data == 8'h0A);
   assign is_bs   = (rx_data == 8'h08) || (rx_data == 8'h7F);
   assign is_data = !is_cr && !is_lf && !is_bs;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic, including the replay read index
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      case (state_q)
         COLLECT: begin
            if (accept && is_cr) begin
               if (cnt_q != '0) begin
                  state_d = EMIT;
                  rd_d    = '0;
               end else begin
                  state_d = EMIT_CR;
               end
            end
         end
         EMIT: begin
            if (tx_hs) begin
               if (rd_q == cnt_q - ONE_L) begin
                  state_d = EMIT_CR;
               end else begin
                  rd_d = rd_q + ONE_L;
               end
            end
         end
         EMIT_CR: begin
            if (tx_hs) begin
               state_d = EMIT_LF;
            end
         end
         EMIT_LF: begin
            if (tx_hs) begin
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   // Output logic
   always_comb begin
      rx_data_ready = (state_q == COLLECT);
      busy          = (state_q != COLLECT);
      line_len      = cnt_q;
      overflow      = overflow_q;
   end

   // Byte to present in the state we are moving to. Looking ahead at
   // state_d/rd_d lets the next byte load on the handshake edge itself,
   // so back-to-back transfers keep tx_data_valid high.
   always_comb begin
      next_byte = 8'h0A;
      case (state_d)
         EMIT:    next_byte = emit_map(line_buf[rd_d[IDX_W-1:0]]);
         EMIT_CR: next_byte = 8'h0D;
         default: next_byte = 8'h0A;
      endcase
   end

   // Datapath: length counter, overflow flag, read index, tx register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         rd_q          <= '0;
         overflow_q    <= 1'b0;
         tx_data       <= 8'h00;
         tx_data_valid <= 1'b0;
      end else begin
         rd_q <= rd_d;

         if (state_q == COLLECT && accept) begin
            if (is_bs) begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - ONE_L;
               end
            end else if (is_data) begin
               if (cnt_q < DEPTH_L) begin
                  cnt_q <= cnt_q + ONE_L;
               end else begin
                  overflow_q <= 1'b1;
               end
            end
         end

         if (state_q == EMIT_LF && tx_hs) begin
            cnt_q      <= '0;
            overflow_q <= 1'b0;
         end

         // Only load while replaying and the register is empty or being
         // consumed; on entry from COLLECT the first byte appears one
         // cycle after the state change.
         if (state_q != COLLECT && (!tx_data_valid || tx_hs)) begin
            if (state_d == COLLECT) begin
               tx_data_valid <= 1'b0;
            end else begin
               tx_data       <= next_byte;
               tx_data_valid <= 1'b1;
            end
         end
      end
   end

   // Line storage is not reset
   always_ff @(posedge clk) begin
      if (state_q == COLLECT && accept && is_data && cnt_q < DEPTH_L) begin
         line_buf[cnt_q[IDX_W-1:0]] <= rx_data;
      end
   end

endmodule

// File: tb/tb_uart_line_buffer.sv
// tb/tb_uart_line_buffer.sv - directed self-checking bench for uart_line_buffer

module tb_uart_line_buffer;

   localparam int DEPTH = 4;
   localparam int LEN_W = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst_n;
   logic [7:0]       rx_data;
   logic             rx_data_valid;
   logic             rx_data_ready;
   logic [7:0]       tx_data;
   logic             tx_data_valid;
   logic             tx_data_ready;
   logic [LEN_W-1:0] line_len;
   logic             overflow;
   logic             busy;

   int checks;
   int failures;
   logic [7:0] txq[$];
   logic [7:0] exp_q[$];

   uart_line_buffer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .line_len      (line_len),
      .overflow      (overflow),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every completed tx handshake
   always @(posedge clk) begin
      if (rst_n && tx_data_valid && tx_data_ready) begin
         txq.push_back(tx_data);
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data       = b;
      rx_data_valid = 1'b1;
      while (!rx_data_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) begin
         failures++;
         $display("FAIL send_timeout byte=%02h rx_data_ready=%b required=1", b, rx_data_ready);
      end
      @(posedge clk);
      @(negedge clk);
      rx_data_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy) begin
         failures++;
         $display("FAIL idle_timeout busy=%b required=0", busy);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      rx_data       = 8'h00;
      rx_data_valid = 1'b0;
      tx_data_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_data, tx_data_valid, line_len, overflow, busy, rx_data_ready} !==
          {8'h00, 1'b0, {LEN_W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_values tx_data=%02h valid=%b len=%0d ovf=%b busy=%b rdy=%b required 00 0 0 0 0 1",
                  tx_data, tx_data_valid, line_len, overflow, busy, rx_data_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_line();
      int hi;
      txq.delete();
      tx_data_ready = 1'b1;
      send_byte(8'h61);
      send_byte(8'h62);
      send_byte(8'h63);
      checks++;
      if (line_len !== 3) begin
         failures++;
         $display("FAIL t1_len_before_cr got=%0d required=3", line_len);
      end
      send_byte(8'h0D);
      checks++;
      if (rx_data_ready !== 1'b0 || busy !== 1'b1 || tx_data_valid !== 1'b0) begin
         failures++;
         $display("FAIL t1_after_cr rdy=%b busy=%b valid=%b required 0 1 0",
                  rx_data_ready, busy, tx_data_valid);
      end
      // Handshake edges 1..6 after the CR edge: busy drops after the 6th
      hi = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy === 1'b1 && rx_data_ready === 1'b0) hi++;
      end
      checks++;
      if (hi !== 6) begin
         failures++;
         $display("FAIL t1_busy_cycles got=%0d required=6", hi);
      end
      exp_q = '{8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A};
      checks++;
      if (txq.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL t1_tx_count got=%0d required=%0d", txq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
         checks++;
         if (txq[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL t1_tx_byte%0d got=%02h required=%02h", i, txq[i], exp_q[i]);
         end
      end
      checks++;
      if (line_len !== 0 || rx_data_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL t1_end len=%0d rdy=%b busy=%b required 0 1 0", line_len, rx_data_ready, busy);
      end
   endtask

   task automatic test_empty_line();
      txq.delete();
      tx_data_ready = 1'b1;
      send_byte(8'h0D);
      wait_idle();
      exp_q = '{8'h0D, 8'h0A};
      checks++;
      if (txq.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL t2_tx_count got=%0d required=%0d", txq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
         checks++;
         if (txq[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL t2_tx_byte%0d got=%02h required=%02h", i, txq[i], exp_q[i]);
         end
      end
      txq.delete();
      send_byte(8'h0A);
      repeat (10) @(negedge clk);
      checks++;
      if (txq.size() !== 0 || line_len !== 0 || busy !== 1'b0 || tx_data_valid !== 1'b0) begin
         failures++;
         $display("FAIL t2_lf_only tx=%0d len=%0d busy=%b valid=%b required 0 0 0 0",
                  txq.size(), line_len, busy, tx_data_valid);
      end
   endtask

   task automatic test_editing();
      txq.delete();
      tx_data_ready = 1'b1;
      send_byte(8'h7F);
      checks++;
      if (line_len !== 0) begin
         failures++;
         $display("FAIL t3_del_on_empty len=%0d required=0", line_len);
      end
      send_byte(8'h61);
      send_byte(8'h62);
      send_byte(8'h08);
      checks++;
      if (line_len !== 1) begin
         failures++;
         $display("FAIL t3_len_after_bs len=%0d required=1", line_len);
      end
      send_byte(8'h63);
      send_byte(8'h0D);
      wait_idle();
`ifdef UART_LINE_UPPER_EN
      exp_q = '{8'h41, 8'h43, 8'h0D, 8'h0A};
`else
      exp_q = '{8'h61, 8'h63, 8'h0D, 8'h0A};
`endif
      checks++;
      if (txq.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL t3_tx_count got=%0d required=%0d", txq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
         checks++;
         if (txq[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL t3_tx_byte%0d got=%02h required=%02h", i, txq[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      txq.delete();
      tx_data_ready = 1'b1;
      send_byte(8'h41);
      send_byte(8'h42);
      send_byte(8'h43);
      send_byte(8'h44);
      checks++;
      if (overflow !== 1'b0 || line_len !== 4) begin
         failures++;
         $display("FAIL t4_full ovf=%b len=%0d required 0 4", overflow, line_len);
      end
      send_byte(8'h45);
      checks++;
      if (overflow !== 1'b1 || line_len !== 4) begin
         failures++;
         $display("FAIL t4_after_E ovf=%b len=%0d required 1 4", overflow, line_len);
      end
      send_byte(8'h46);
      send_byte(8'h0D);
      checks++;
      if (overflow !== 1'b1) begin
         failures++;
         $display("FAIL t4_ovf_during_replay ovf=%b required=1", overflow);
      end
      wait_idle();
      exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
      checks++;
      if (txq.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL t4_tx_count got=%0d required=%0d", txq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
         checks++;
         if (txq[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL t4_tx_byte%0d got=%02h required=%02h", i, txq[i], exp_q[i]);
         end
      end
      checks++;
      if (overflow !== 1'b0 || line_len !== 0) begin
         failures++;
         $display("FAIL t4_end ovf=%b len=%0d required 0 0", overflow, line_len);
      end
   endtask

   task automatic test_backpressure();
      int n;
      txq.delete();
      tx_data_ready = 1'b0;
      send_byte(8'h78);
      send_byte(8'h79);
      send_byte(8'h7A);
      send_byte(8'h0D);
      n = 0;
      while (!tx_data_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tx_data_valid !== 1'b1 || tx_data !== 8'h78) begin
         failures++;
         $display("FAIL t5_first valid=%b data=%02h required 1 78", tx_data_valid, tx_data);
      end
      tx_data_ready = 1'b1;
      @(negedge clk);
      tx_data_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (tx_data_valid !== 1'b1 || tx_data !== 8'h79) begin
            failures++;
            $display("FAIL t5_stall%0d valid=%b data=%02h required 1 79", i, tx_data_valid, tx_data);
         end
      end
      n = 0;
      while (busy && n < 300) begin
         tx_data_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      tx_data_ready = 1'b1;
      wait_idle();
      exp_q = '{8'h78, 8'h79, 8'h7A, 8'h0D, 8'h0A};
`ifdef UART_LINE_UPPER_EN
      exp_q = '{8'h58, 8'h59, 8'h5A, 8'h0D, 8'h0A};
`endif
      checks++;
      if (txq.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL t5_tx_count got=%0d required=%0d", txq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
         checks++;
         if (txq[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL t5_tx_byte%0d got=%02h required=%02h", i, txq[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_replay();
      int n;
      txq.delete();
      tx_data_ready = 1'b1;
      send_byte(8'h6D);
      send_byte(8'h6E);
      send_byte(8'h6F);
      send_byte(8'h0D);
      n = 0;
      while (!(tx_data_valid && (tx_data == 8'h6E || tx_data == 8'h4E)) && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin
         failures++;
         $display("FAIL t6_reach_byte2 valid=%b data=%02h required 1 6E", tx_data_valid, tx_data);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_data_valid, line_len, busy, rx_data_ready, overflow} !==
          {1'b0, {LEN_W{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL t6_async_reset valid=%b len=%0d busy=%b rdy=%b ovf=%b required 0 0 0 1 0",
                  tx_data_valid, line_len, busy, rx_data_ready, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txq.delete();
      send_byte(8'h71);
      send_byte(8'h0D);
      wait_idle();
`ifdef UART_LINE_UPPER_EN
      exp_q = '{8'h51, 8'h0D, 8'h0A};
`else
      exp_q = '{8'h71, 8'h0D, 8'h0A};
`endif
      checks++;
      if (txq.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL t6_tx_count got=%0d required=%0d", txq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
         checks++;
         if (txq[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL t6_tx_byte%0d got=%02h required=%02h", i, txq[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_line();
      test_empty_line();
      test_editing();
      test_overflow();
      test_backpressure();
      test_reset_mid_replay();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
